// File: rtl/m92_pkg.sv
// Shared types for the m92 CPU SDRAM channel: command word, responder state
// encoding and the byte-enable merge used to keep the read cache coherent.
package m92_pkg;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  be;
    logic [15:0] data;
  } sdr_cpu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sdr_port_state_t;

  function automatic logic [15:0] merge_be(input logic [15:0] old,
                                           input logic [15:0] wdata,
                                           input logic [1:0]  be);
    merge_be = old;
    if (be[1]) merge_be[15:8] = wdata[15:8];
    if (be[0]) merge_be[7:0]  = wdata[7:0];
  endfunction

endpackage

// File: rtl/m92_sdr_cpu_port.sv
// Responder end of the CPU SDRAM channel: executes each request on the backend
// port (or from the one-word read cache) and answers with a single rdy pulse.
//
//   state | meaning
//   IDLE  | waiting for the active slot; hit -> RESP, miss/write -> ISSUE
//   ISSUE | mem_req held with the slot contents until mem_ack
//   WAIT  | read accepted, waiting for mem_valid
//   RESP  | rdy pulse, active slot retired, pending slot promoted
module m92_sdr_cpu_port
  import m92_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk_ram,
  input  logic        reset_n,
  input  logic        sdr_cpu_req,
  input  logic [24:0] sdr_cpu_addr,
  input  logic [1:0]  sdr_cpu_wr_sel,
  input  logic [15:0] sdr_cpu_din,
  output logic [15:0] sdr_cpu_dout,
  output logic        sdr_cpu_rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic [15:0] mem_rdata,
  output logic        overflow
);

  sdr_port_state_t state;
  sdr_cpu_cmd_t    slot;
  sdr_cpu_cmd_t    pend;
  logic            slot_full;
  logic            pend_full;
  logic            c_valid;
  logic [23:0]     c_addr;
  logic [15:0]     c_data;

  sdr_cpu_cmd_t    req_cmd;
  logic            cache_hit;
  logic            unused_addr_lsb;

  assign req_cmd         = '{sdr_cpu_addr[24:1], sdr_cpu_wr_sel, sdr_cpu_din};
  assign unused_addr_lsb = sdr_cpu_addr[0];
  assign cache_hit       = CACHE_EN && (slot.be == 2'b00) && c_valid &&
                           (c_addr == slot.addr);

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      slot         <= '0;
      pend         <= '0;
      slot_full    <= 1'b0;
      pend_full    <= 1'b0;
      c_valid      <= 1'b0;
      c_addr       <= '0;
      c_data       <= '0;
      sdr_cpu_dout <= '0;
      sdr_cpu_rdy  <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      overflow     <= 1'b0;
    end else begin
      sdr_cpu_rdy <= 1'b0;

      // RESP retires the active slot, so a request landing there always fits.
      if (state == RESP) begin
        if (pend_full) begin
          slot      <= pend;
          slot_full <= 1'b1;
          pend_full <= sdr_cpu_req;
          if (sdr_cpu_req) pend <= req_cmd;
        end else begin
          slot_full <= sdr_cpu_req;
          if (sdr_cpu_req) slot <= req_cmd;
        end
      end else if (sdr_cpu_req) begin
        if (!slot_full) begin
          slot      <= req_cmd;
          slot_full <= 1'b1;
        end else if (!pend_full) begin
          pend      <= req_cmd;
          pend_full <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (slot_full) begin
            if (cache_hit) begin
              sdr_cpu_dout <= c_data;
              sdr_cpu_rdy  <= 1'b1;
              state        <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= |slot.be;
              mem_be    <= slot.be;
              mem_addr  <= slot.addr;
              mem_wdata <= slot.data;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              if (c_valid && (c_addr == slot.addr))
                c_data <= merge_be(c_data, slot.data, slot.be);
              sdr_cpu_rdy <= 1'b1;
              state       <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_valid) begin
            sdr_cpu_dout <= mem_rdata;
            c_valid      <= 1'b1;
            c_addr       <= slot.addr;
            c_data       <= mem_rdata;
            sdr_cpu_rdy  <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
